// File: rtl/ber_sweep_ctrl.sv
// ber_sweep_ctrl: steps the PHY bit-error injector through a table of
// error-rate thresholds. For each step it loads the threshold, waits out the
// channel/receiver latency, then counts injected against detected errors over
// a dwell window and flags the step as failed when the two counts drift apart
// by more than err_limit_i.
//
// Optional build macro BER_SWEEP_EARLY_EXIT_EN: when defined, RUN ends as soon
// as the running count difference exceeds err_limit_i instead of completing
// the full dwell.
//
// Output strobes: result_valid_o, done_o and aborted_o are single-cycle pulses
// with no ready/back-pressure. inj_cnt_o, det_cnt_o and step_fail_o are valid
// while result_valid_o is high and stay stable until the next threshold load.
module ber_sweep_ctrl #(
   parameter int NUM_STEPS  = 4,
   parameter int THR_W      = 32,
   parameter int DWELL_W    = 24,
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = 4,
   localparam int IDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   input  logic                       abort_i,
   input  logic [NUM_STEPS*THR_W-1:0] thr_table_i,
   input  logic [DWELL_W-1:0]         dwell_len_i,
   input  logic [CNT_W-1:0]           err_limit_i,
   input  logic                       error_injected_i,
   input  logic                       rx_err_i,
   output logic                       ch_enable_o,
   output logic [THR_W-1:0]           ch_thr_o,
   output logic                       busy_o,
   output logic [IDX_W-1:0]           step_idx_o,
   output logic [CNT_W-1:0]           inj_cnt_o,
   output logic [CNT_W-1:0]           det_cnt_o,
   output logic                       result_valid_o,
   output logic [NUM_STEPS-1:0]       step_fail_o,
   output logic                       done_o,
   output logic                       aborted_o,
   output logic [2:0]                 dbg_state_o
);

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_RUN    = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     step_idx_q;
   logic [SET_W-1:0]     settle_q;
   logic [DWELL_W-1:0]   dwell_q;
   logic [CNT_W-1:0]     inj_cnt_q, det_cnt_q;
   logic [CNT_W-1:0]     inj_cnt_d, det_cnt_d;
   logic                 ch_en_q;
   logic [THR_W-1:0]     ch_thr_q;
   logic [NUM_STEPS-1:0] step_fail_q;
   logic                 result_valid_q, done_q, aborted_q;

   logic [THR_W-1:0]     thr_sel;
   logic [DWELL_W-1:0]   dwell_last;
   logic [CNT_W:0]       chk_diff;
   logic                 early_exit;

   // |a - b| with one extra bit so the subtraction never wraps
   function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] ax;
      logic [CNT_W:0] bx;
      ax = {1'b0, a};
      bx = {1'b0, b};
      return (ax >= bx) ? (ax - bx) : (bx - ax);
   endfunction

   // Table lookup, dwell terminal count (0 behaves as 1) and CHECK verdict input
   always_comb begin
      thr_sel    = thr_table_i[int'(step_idx_q) * THR_W +: THR_W];
      dwell_last = (dwell_len_i == '0) ? '0 : dwell_len_i - DWELL_W'(1);
      chk_diff   = abs_diff(inj_cnt_q, det_cnt_q);
   end

   // Saturating next-count values for the RUN window
   always_comb begin
      inj_cnt_d = inj_cnt_q;
      det_cnt_d = det_cnt_q;
      if (error_injected_i && (inj_cnt_q != '1)) inj_cnt_d = inj_cnt_q + CNT_W'(1);
      if (rx_err_i && (det_cnt_q != '1))         det_cnt_d = det_cnt_q + CNT_W'(1);
   end

`ifdef BER_SWEEP_EARLY_EXIT_EN
   logic [CNT_W:0] run_diff;
   // Running difference including this cycle's pulses, so RUN leaves right after the offending pulse
   always_comb run_diff = abs_diff(inj_cnt_d, det_cnt_d);
   assign early_exit = (run_diff > {1'b0, err_limit_i});
`else
   assign early_exit = 1'b0;
`endif

   // Sweep sequencer with registered channel controls and result strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         step_idx_q     <= '0;
         settle_q       <= '0;
         dwell_q        <= '0;
         inj_cnt_q      <= '0;
         det_cnt_q      <= '0;
         ch_en_q        <= 1'b0;
         ch_thr_q       <= '0;
         step_fail_q    <= '0;
         result_valid_q <= 1'b0;
         done_q         <= 1'b0;
         aborted_q      <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         done_q         <= 1'b0;
         aborted_q      <= 1'b0;
         if ((state_q != S_IDLE) && abort_i) begin
            // Abort wins over every other transition; verdicts and counts are kept
            state_q   <= S_IDLE;
            ch_en_q   <= 1'b0;
            ch_thr_q  <= '0;
            aborted_q <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_i && !abort_i) begin
                     state_q     <= S_LOAD;
                     step_idx_q  <= '0;
                     step_fail_q <= '0;
                  end
               end
               S_LOAD: begin
                  ch_thr_q  <= thr_sel;
                  ch_en_q   <= 1'b1;
                  inj_cnt_q <= '0;
                  det_cnt_q <= '0;
                  settle_q  <= SETTLE_LAST;
                  dwell_q   <= dwell_last;
                  state_q   <= (SETTLE_CYC == 0) ? S_RUN : S_SETTLE;
               end
               S_SETTLE: begin
                  if (settle_q == '0) state_q <= S_RUN;
                  else                settle_q <= settle_q - SET_W'(1);
               end
               S_RUN: begin
                  inj_cnt_q <= inj_cnt_d;
                  det_cnt_q <= det_cnt_d;
                  if ((dwell_q == '0) || early_exit) state_q <= S_CHECK;
                  else                               dwell_q <= dwell_q - DWELL_W'(1);
               end
               S_CHECK: begin
                  result_valid_q <= 1'b1;
                  if (chk_diff > {1'b0, err_limit_i}) step_fail_q[step_idx_q] <= 1'b1;
                  if (step_idx_q == LAST_IDX) begin
                     state_q <= S_DONE;
                  end else begin
                     step_idx_q <= step_idx_q + IDX_W'(1);
                     state_q    <= S_LOAD;
                  end
               end
               S_DONE: begin
                  ch_en_q  <= 1'b0;
                  ch_thr_q <= '0;
                  done_q   <= 1'b1;
                  state_q  <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign ch_enable_o    = ch_en_q;
   assign ch_thr_o       = ch_thr_q;
   assign busy_o         = (state_q != S_IDLE);
   assign step_idx_o     = step_idx_q;
   assign inj_cnt_o      = inj_cnt_q;
   assign det_cnt_o      = det_cnt_q;
   assign result_valid_o = result_valid_q;
   assign step_fail_o    = step_fail_q;
   assign done_o         = done_q;
   assign aborted_o      = aborted_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Directed bench for ber_sweep_ctrl (4 steps, 4-bit counters, settle of 4).
// Timing reference used throughout: rel = number of clock edges after the
// edge that sampled start_i. Step s occupies rel P*s .. P*s+P-1 with
// P = 2 + SETTLE_CYC + dwell; result_valid_o for step s is seen at rel P*(s+1)
// and done_o at rel P*NUM_STEPS+1.
module tb_ber_sweep_ctrl;

   localparam int NUM_STEPS  = 4;
   localparam int THR_W      = 32;
   localparam int DWELL_W    = 24;
   localparam int CNT_W      = 4;
   localparam int SETTLE_CYC = 4;
   localparam int IDX_W      = 2;

   logic                       clk;
   logic                       rst_n;
   logic                       start_i;
   logic                       abort_i;
   logic [NUM_STEPS*THR_W-1:0] thr_table_i;
   logic [DWELL_W-1:0]         dwell_len_i;
   logic [CNT_W-1:0]           err_limit_i;
   logic                       error_injected_i;
   logic                       rx_err_i;
   logic                       ch_enable_o;
   logic [THR_W-1:0]           ch_thr_o;
   logic                       busy_o;
   logic [IDX_W-1:0]           step_idx_o;
   logic [CNT_W-1:0]           inj_cnt_o;
   logic [CNT_W-1:0]           det_cnt_o;
   logic                       result_valid_o;
   logic [NUM_STEPS-1:0]       step_fail_o;
   logic                       done_o;
   logic                       aborted_o;
   logic [2:0]                 dbg_state;

   ber_sweep_ctrl #(
      .NUM_STEPS(NUM_STEPS), .THR_W(THR_W), .DWELL_W(DWELL_W),
      .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .thr_table_i(thr_table_i), .dwell_len_i(dwell_len_i), .err_limit_i(err_limit_i),
      .error_injected_i(error_injected_i), .rx_err_i(rx_err_i),
      .ch_enable_o(ch_enable_o), .ch_thr_o(ch_thr_o), .busy_o(busy_o),
      .step_idx_o(step_idx_o), .inj_cnt_o(inj_cnt_o), .det_cnt_o(det_cnt_o),
      .result_valid_o(result_valid_o), .step_fail_o(step_fail_o),
      .done_o(done_o), .aborted_o(aborted_o), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset / receiver loopback ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       loop_en;
   logic       rx_drv;
   logic [1:0] inj_dly;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) inj_dly <= 2'b00;
      else        inj_dly <= {inj_dly[0], error_injected_i};
   end
   assign rx_err_i = loop_en ? inj_dly[1] : rx_drv;

   logic [1+THR_W+1+IDX_W+2*CNT_W+1+NUM_STEPS+1+1-1:0] outs_all;
   assign outs_all = {ch_enable_o, ch_thr_o, busy_o, step_idx_o, inj_cnt_o, det_cnt_o,
                      result_valid_o, step_fail_o, done_o, aborted_o};

   // ---------------- bookkeeping ----------------
   int checks;
   int errors;

   logic [THR_W-1:0] thr_exp [NUM_STEPS];
   logic [THR_W-1:0] exp_q[$];

   int   inj_list[$];
   int   inj_step;
   logic hold_inj;

   int               rv_rel_q[$];
   logic [CNT_W-1:0] rv_inj_q[$];
   logic [CNT_W-1:0] rv_det_q[$];
   int               done_rel_q[$];
   int               ab_rel_q[$];
   logic [THR_W-1:0] thr_q[$];
   logic             en_run_q[$];
   logic             busy_q[$];
   logic             en_q[$];
   logic [IDX_W-1:0] idx_q[$];
   logic [NUM_STEPS-1:0] fail_q[$];

   // ---------------- driver ----------------
   // Pulses start_i, then runs n_cyc cycles recording outputs per cycle and
   // driving error_injected_i on the listed RUN cycles of the chosen step.
   task automatic sweep(input int dwell_eff, input int n_cyc, input int abort_at, input int start_at);
      int   p;
      int   s;
      int   local_c;
      int   r;
      logic hit;
      p = 2 + SETTLE_CYC + dwell_eff;
      rv_rel_q.delete(); rv_inj_q.delete(); rv_det_q.delete();
      done_rel_q.delete(); ab_rel_q.delete(); thr_q.delete(); en_run_q.delete();
      busy_q.delete(); en_q.delete(); idx_q.delete(); fail_q.delete();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int rel = 0; rel < n_cyc; rel++) begin
         s       = rel / p;
         local_c = rel % p;
         r       = local_c - SETTLE_CYC;
         if (result_valid_o) begin
            rv_rel_q.push_back(rel);
            rv_inj_q.push_back(inj_cnt_o);
            rv_det_q.push_back(det_cnt_o);
         end
         if (done_o)    done_rel_q.push_back(rel);
         if (aborted_o) ab_rel_q.push_back(rel);
         if (local_c == SETTLE_CYC + 1) begin
            thr_q.push_back(ch_thr_o);
            en_run_q.push_back(ch_enable_o);
         end
         busy_q.push_back(busy_o);
         en_q.push_back(ch_enable_o);
         idx_q.push_back(step_idx_o);
         fail_q.push_back(step_fail_o);
         hit = 1'b0;
         if (r >= 1 && r <= dwell_eff && (inj_step < 0 || inj_step == s))
            foreach (inj_list[i]) if (inj_list[i] == r) hit = 1'b1;
         error_injected_i = hold_inj | hit;
         start_i          = (rel == start_at);
         abort_i          = (rel == abort_at);
         @(negedge clk);
      end
      error_injected_i = 1'b0;
      start_i          = 1'b0;
      abort_i          = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (outs_all !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", outs_all);
      end
      checks++;
      if (dbg_state !== 3'd0) begin
         errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy_o);
      end
   endtask

   task automatic test_matched_loopback();
      int exp_rel;
      loop_en     = 1'b1;
      inj_step    = -1;
      inj_list    = '{10, 20, 30, 40, 50};
      err_limit_i = '0;
      dwell_len_i = 24'd100;
      sweep(100, 430, -1, -1);
      checks++;
      if (rv_rel_q.size() !== 4) begin
         errors++; $display("FAIL loop_rv_count: got %0d expected 4", rv_rel_q.size());
      end
      for (int k = 0; k < 4; k++) begin
         exp_rel = 106 * (k + 1);
         checks++;
         if (k >= rv_rel_q.size()) begin
            errors++; $display("FAIL loop_rv_missing: step %0d got none expected rel %0d", k, exp_rel);
         end else if (rv_rel_q[k] !== exp_rel || rv_inj_q[k] !== 4'd5 || rv_det_q[k] !== 4'd5) begin
            errors++;
            $display("FAIL loop_rv_step%0d: got rel %0d inj %0d det %0d expected rel %0d inj 5 det 5",
                     k, rv_rel_q[k], rv_inj_q[k], rv_det_q[k], exp_rel);
         end
      end
      checks++;
      if (done_rel_q.size() !== 1 || (done_rel_q.size() == 1 && done_rel_q[0] !== 425)) begin
         errors++; $display("FAIL loop_done_time: got %0d pulses first at %0d expected 1 at 425",
                            done_rel_q.size(), (done_rel_q.size() > 0) ? done_rel_q[0] : -1);
      end
      checks++;
      if (step_fail_o !== 4'b0000) begin
         errors++; $display("FAIL loop_step_fail: got %b expected 0000", step_fail_o);
      end
      checks++;
      if (en_q[106] !== 1'b1 || en_q[424] !== 1'b1) begin
         errors++; $display("FAIL loop_enable_between_steps: got %b %b expected 1 1", en_q[106], en_q[424]);
      end
      checks++;
      if ({busy_o, ch_enable_o, ch_thr_o} !== '0) begin
         errors++; $display("FAIL loop_end_idle: got busy %b en %b thr %h expected 0 0 0",
                            busy_o, ch_enable_o, ch_thr_o);
      end
      loop_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_fail_step();
      logic [THR_W-1:0] e;
      inj_step    = 2;
      inj_list    = '{3, 9, 27};
      err_limit_i = 4'd2;
      dwell_len_i = 24'd30;
      sweep(30, 4 * 36 + 4, -1, -1);
      checks++;
      if (step_fail_o !== 4'b0100) begin
         errors++; $display("FAIL fail_step2_flags: got %b expected 0100", step_fail_o);
      end
      checks++;
      if (rv_inj_q.size() !== 4) begin
         errors++; $display("FAIL fail_step2_rv_count: got %0d expected 4", rv_inj_q.size());
      end else if (rv_inj_q[0] !== 0 || rv_inj_q[1] !== 0 || rv_inj_q[2] !== 4'd3 || rv_inj_q[3] !== 0 ||
                   rv_det_q[2] !== 0) begin
         errors++; $display("FAIL fail_step2_counts: got inj %0d %0d %0d %0d det2 %0d expected 0 0 3 0 det2 0",
                            rv_inj_q[0], rv_inj_q[1], rv_inj_q[2], rv_inj_q[3], rv_det_q[2]);
      end
      for (int k = 0; k < NUM_STEPS; k++) exp_q.push_back(thr_exp[k]);
      for (int k = 0; k < NUM_STEPS; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (k >= thr_q.size()) begin
            errors++; $display("FAIL run_thr_missing: step %0d got none expected %h", k, e);
         end else if (thr_q[k] !== e || en_run_q[k] !== 1'b1) begin
            errors++; $display("FAIL run_thr_step%0d: got thr %h en %b expected thr %h en 1",
                               k, thr_q[k], en_run_q[k], e);
         end
      end
   endtask

   task automatic test_abort();
      inj_step    = 0;
      inj_list    = '{5};
      err_limit_i = '0;
      dwell_len_i = 24'd30;
      sweep(30, 60, 50, -1);
      checks++;
      if (ab_rel_q.size() !== 1 || (ab_rel_q.size() == 1 && ab_rel_q[0] !== 51)) begin
         errors++; $display("FAIL abort_pulse: got %0d pulses first at %0d expected 1 at 51",
                            ab_rel_q.size(), (ab_rel_q.size() > 0) ? ab_rel_q[0] : -1);
      end
      checks++;
      if (busy_q[50] !== 1'b1 || busy_q[51] !== 1'b0 || en_q[51] !== 1'b0) begin
         errors++; $display("FAIL abort_idle: got busy50 %b busy51 %b en51 %b expected 1 0 0",
                            busy_q[50], busy_q[51], en_q[51]);
      end
      checks++;
      if (done_rel_q.size() !== 0 || rv_rel_q.size() !== 1) begin
         errors++; $display("FAIL abort_no_done: got done %0d rv %0d expected 0 1",
                            done_rel_q.size(), rv_rel_q.size());
      end
      checks++;
      if (step_fail_o !== 4'b0001 || ch_thr_o !== '0) begin
         errors++; $display("FAIL abort_hold: got fail %b thr %h expected 0001 0", step_fail_o, ch_thr_o);
      end
      inj_list.delete();
      sweep(30, 4 * 36 + 4, -1, -1);
      checks++;
      if (idx_q[0] !== 2'd0 || fail_q[0] !== 4'b0000) begin
         errors++; $display("FAIL restart_clear: got idx %0d fail %b expected 0 0000", idx_q[0], fail_q[0]);
      end
      checks++;
      if (done_rel_q.size() !== 1 || (done_rel_q.size() == 1 && done_rel_q[0] !== 145) || step_fail_o !== 4'b0000) begin
         errors++; $display("FAIL restart_done: got %0d pulses fail %b expected 1 at 145 fail 0000",
                            done_rel_q.size(), step_fail_o);
      end
   endtask

   task automatic test_saturation();
      hold_inj    = 1'b1;
      inj_list.delete();
      inj_step    = -1;
      err_limit_i = 4'd14;
      dwell_len_i = 24'd40;
      sweep(40, 4 * 46 + 2, -1, -1);
      checks++;
      if (rv_inj_q.size() < 1 || rv_inj_q[0] !== 4'd15 || rv_det_q[0] !== 4'd0) begin
         errors++; $display("FAIL sat_count: got inj %0d det %0d expected 15 0",
                            (rv_inj_q.size() > 0) ? rv_inj_q[0] : 'x, (rv_det_q.size() > 0) ? rv_det_q[0] : 'x);
      end
      checks++;
      if (step_fail_o !== 4'b1111) begin
         errors++; $display("FAIL sat_limit14: got %b expected 1111", step_fail_o);
      end
      err_limit_i = 4'd15;
      sweep(40, 4 * 46 + 2, -1, -1);
      hold_inj = 1'b0;
      checks++;
      if (step_fail_o !== 4'b0000 || rv_inj_q.size() !== 4) begin
         errors++; $display("FAIL sat_limit15_boundary: got fail %b rv %0d expected 0000 4",
                            step_fail_o, rv_inj_q.size());
      end
   endtask

   task automatic test_dwell_zero();
      inj_step    = 1;
      inj_list    = '{1};
      err_limit_i = '0;
      dwell_len_i = '0;
      sweep(1, 4 * 7 + 3, -1, 16);
      checks++;
      if (rv_rel_q.size() !== 4) begin
         errors++; $display("FAIL dwell0_rv_count: got %0d expected 4", rv_rel_q.size());
      end else if (rv_rel_q[0] !== 7 || rv_rel_q[1] !== 14 || rv_rel_q[2] !== 21 || rv_rel_q[3] !== 28) begin
         errors++; $display("FAIL dwell0_rv_times: got %0d %0d %0d %0d expected 7 14 21 28",
                            rv_rel_q[0], rv_rel_q[1], rv_rel_q[2], rv_rel_q[3]);
      end
      checks++;
      if (done_rel_q.size() !== 1 || (done_rel_q.size() == 1 && done_rel_q[0] !== 29)) begin
         errors++; $display("FAIL dwell0_done: got %0d pulses expected 1 at 29", done_rel_q.size());
      end
      checks++;
      if (step_fail_o !== 4'b0010 || rv_inj_q.size() < 2 || rv_inj_q[1] !== 4'd1) begin
         errors++; $display("FAIL start_ignored_busy: got fail %b expected 0010 with step1 inj 1", step_fail_o);
      end
   endtask

   task automatic test_async_reset();
      inj_list.delete();
      dwell_len_i = 24'd100;
      sweep(100, 3, -1, -1);
      checks++;
      if ({busy_o, ch_enable_o} !== 2'b11) begin
         errors++; $display("FAIL settle_active: got busy %b en %b expected 1 1", busy_o, ch_enable_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs_all !== '0 || dbg_state !== 3'd0) begin
         errors++; $display("FAIL async_reset: got %h state %0d expected 0 0", outs_all, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy_o, aborted_o, done_o} !== 3'b000) begin
         errors++; $display("FAIL reset_no_pulse: got busy %b ab %b done %b expected 0 0 0",
                            busy_o, aborted_o, done_o);
      end
   endtask

   task automatic test_early_exit();
      int exp_rv;
`ifdef BER_SWEEP_EARLY_EXIT_EN
      exp_rv = 13;
`else
      exp_rv = 2 + SETTLE_CYC + 1000;
`endif
      inj_step    = 0;
      inj_list    = '{3, 7};
      err_limit_i = 4'd1;
      dwell_len_i = 24'd1000;
      sweep(1000, exp_rv + 4, exp_rv + 1, -1);
      checks++;
      if (rv_rel_q.size() < 1 || rv_rel_q[0] !== exp_rv || rv_inj_q[0] !== 4'd2) begin
         errors++; $display("FAIL early_exit_timing: got rel %0d inj %0d expected rel %0d inj 2",
                            (rv_rel_q.size() > 0) ? rv_rel_q[0] : -1,
                            (rv_inj_q.size() > 0) ? rv_inj_q[0] : 'x, exp_rv);
      end
      checks++;
      if (step_fail_o !== 4'b0001 || ab_rel_q.size() !== 1) begin
         errors++; $display("FAIL early_exit_verdict: got fail %b aborts %0d expected 0001 1",
                            step_fail_o, ab_rel_q.size());
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      dwell_len_i = '0; err_limit_i = '0;
      error_injected_i = 1'b0; rx_drv = 1'b0; loop_en = 1'b0;
      hold_inj = 1'b0; inj_step = -1;
      thr_exp[0] = 32'hAAAA_0001;
      thr_exp[1] = 32'hBBBB_0002;
      thr_exp[2] = 32'hCCCC_0003;
      thr_exp[3] = 32'hDDDD_0004;
      thr_table_i = {thr_exp[3], thr_exp[2], thr_exp[1], thr_exp[0]};

      test_reset();
      test_matched_loopback();
      test_fail_step();
      test_abort();
      test_saturation();
      test_dwell_zero();
      test_async_reset();
      test_early_exit();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
